// File: rtl/kyber_ntt_addr_gen.sv
// Address sequencer for the 7-layer Kyber forward NTT.
// One butterfly per cycle, write-back addresses delayed to match the datapath.
module kyber_ntt_addr_gen #(
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ready_i,
  output logic       issue_valid,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [6:0] zeta_idx,
  output logic [2:0] layer,
  output logic       wb_valid,
  output logic [7:0] wb_addr_a,
  output logic [7:0] wb_addr_b,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [6:0] bcnt_q, bcnt_d;
  logic [3:0] dcnt_q, dcnt_d;

  logic [PIPE_LAT-1:0]      wv_q, wv_d;
  logic [PIPE_LAT-1:0][7:0] wa_q, wa_d;
  logic [PIPE_LAT-1:0][7:0] wb_q, wb_d;

  logic [7:0] len;
  logic [7:0] mask;
  logic [7:0] bc8;
  logic [7:0] group;
  logic [7:0] a_raw;
  logic [7:0] b_raw;
  logic [7:0] z_raw;
  logic       in_issue;
  logic       accept;

  // group*2*len equals the bcnt bits above the offset, shifted up by one
  always_comb begin
    bc8   = {1'b0, bcnt_q};
    len   = 8'd128 >> layer_q;
    mask  = len - 8'd1;
    group = bc8 >> (3'd7 - layer_q);
    a_raw = ((bc8 & ~mask) << 1) | (bc8 & mask);
    b_raw = a_raw + len;
    z_raw = (8'd1 << layer_q) + group;
  end

  assign in_issue = (state_q == S_ISSUE);
  assign accept   = in_issue & ready_i;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          layer_d = 3'd0;
          bcnt_d  = 7'd0;
        end
      end
      S_ISSUE: begin
        if (ready_i) begin
          bcnt_d = bcnt_q + 7'd1;
          if (bcnt_q == 7'd127) begin
            state_d = S_DRAIN;
            dcnt_d  = 4'd0;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 4'(PIPE_LAT - 1)) begin
          if (layer_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            bcnt_d  = 7'd0;
          end
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line runs every cycle; stalled slots enter as empty bubbles
  always_comb begin
    wv_d    = wv_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    wv_d[0] = accept;
    wa_d[0] = accept ? a_raw : 8'd0;
    wb_d[0] = accept ? b_raw : 8'd0;
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      wv_d[i] = wv_q[i-1];
      wa_d[i] = wa_q[i-1];
      wb_d[i] = wb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= 3'd0;
      bcnt_q  <= 7'd0;
      dcnt_q  <= 4'd0;
      wv_q    <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      wv_q    <= wv_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

  assign issue_valid = in_issue;
  assign addr_a      = in_issue ? a_raw : 8'd0;
  assign addr_b      = in_issue ? b_raw : 8'd0;
  assign zeta_idx    = in_issue ? z_raw[6:0] : 7'd0;
  assign layer       = layer_q;
  assign wb_valid    = wv_q[PIPE_LAT-1];
  assign wb_addr_a   = wa_q[PIPE_LAT-1];
  assign wb_addr_b   = wb_q[PIPE_LAT-1];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_kyber_ntt_addr_gen.sv
// Scoreboard bench: a reference NTT loop fills the expected queues,
// a negedge monitor pops and compares on every issue and write-back.
module tb_kyber_ntt_addr_gen;

  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ready_i;
  logic       issue_valid;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [6:0] zeta_idx;
  logic [2:0] layer;
  logic       wb_valid;
  logic [7:0] wb_addr_a;
  logic [7:0] wb_addr_b;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  kyber_ntt_addr_gen #(.PIPE_LAT(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready_i    (ready_i),
    .issue_valid(issue_valid),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .zeta_idx   (zeta_idx),
    .layer      (layer),
    .wb_valid   (wb_valid),
    .wb_addr_a  (wb_addr_a),
    .wb_addr_b  (wb_addr_b),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] z;
    logic [2:0] l;
  } beat_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         t;
  } wb_t;

  beat_t exp_q[$];
  wb_t   wbq[$];
  int    errors = 0;
  int    checks = 0;
  int    edge_n = 0;
  int    s0 = 0;
  int    exp_done = -1;
  int    n_iss, n_wb, n_done;
  bit    done_seen;
  int    cov[7][256];
  beat_t e;
  wb_t   w;
  int    cyc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic fill_model();
    int k;
    int l;
    k = 1;
    l = 0;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++)
          exp_q.push_back('{a: 8'(j), b: 8'(j + len),
                            z: 7'(k), l: 3'(l)});
        k++;
      end
      l++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  initial forever begin
    @(negedge clk);
    cyc = edge_n - s0;
    if (!rst) begin
      if (issue_valid && ready_i) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_issue");
        end else begin
          e = exp_q.pop_front();
          chk("addr_a", 32'(addr_a), 32'(e.a));
          chk("addr_b", 32'(addr_b), 32'(e.b));
          chk("zeta_idx", 32'(zeta_idx), 32'(e.z));
          chk("layer", 32'(layer), 32'(e.l));
          wbq.push_back('{a: e.a, b: e.b, t: cyc});
        end
        case (n_iss)
          0: begin
            chk("first_a", 32'(addr_a), 0);
            chk("first_b", 32'(addr_b), 128);
            chk("first_z", 32'(zeta_idx), 1);
            chk("first_cyc", cyc, 1);
          end
          296: begin
            chk("l2b40_a", 32'(addr_a), 72);
            chk("l2b40_b", 32'(addr_b), 104);
            chk("l2b40_z", 32'(zeta_idx), 5);
          end
          773: begin
            chk("l6b5_a", 32'(addr_a), 9);
            chk("l6b5_b", 32'(addr_b), 11);
            chk("l6b5_z", 32'(zeta_idx), 66);
          end
          895: begin
            chk("last_a", 32'(addr_a), 253);
            chk("last_b", 32'(addr_b), 255);
            chk("last_z", 32'(zeta_idx), 127);
          end
          default: ;
        endcase
        if (layer < 3'd7) begin
          cov[layer][addr_a]++;
          cov[layer][addr_b]++;
        end
        n_iss++;
      end else if (issue_valid && exp_q.size() > 0) begin
        chk("stall_a", 32'(addr_a), 32'(exp_q[0].a));
        chk("stall_z", 32'(zeta_idx), 32'(exp_q[0].z));
      end
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          fail_now("extra_wb");
        end else begin
          w = wbq.pop_front();
          chk("wb_addr_a", 32'(wb_addr_a), 32'(w.a));
          chk("wb_addr_b", 32'(wb_addr_b), 32'(w.b));
          chk("wb_latency", cyc - w.t, P);
        end
        if (n_wb == 296) begin
          chk("l2b40_wb_a", 32'(wb_addr_a), 72);
          chk("l2b40_wb_b", 32'(wb_addr_b), 104);
        end
        n_wb++;
      end
      if (done) begin
        n_done++;
        done_seen = 1'b1;
        chk("done_cycle", cyc, exp_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_xfer(int done_at);
    for (int l = 0; l < 7; l++)
      for (int a = 0; a < 256; a++)
        cov[l][a] = 0;
    n_iss = 0;
    n_wb = 0;
    n_done = 0;
    done_seen = 1'b0;
    exp_q.delete();
    wbq.delete();
    fill_model();
    exp_done = done_at;
    start = 1'b1;
    s0 = edge_n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_iss(int n);
    for (int i = 0; i < 2000 && n_iss < n; i++) step();
    if (n_iss < n) fail_now("timeout_issue");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1500 && !done_seen; i++) step();
    if (!done_seen) fail_now("timeout_done");
    repeat (P + 2) step();
  endtask

  task automatic end_checks();
    int bad;
    chk("issue_count", n_iss, 896);
    chk("wb_count", n_wb, 896);
    chk("done_count", n_done, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("wb_left", wbq.size(), 0);
    for (int l = 0; l < 7; l++) begin
      bad = 0;
      for (int a = 0; a < 256; a++)
        if (cov[l][a] != 1) bad++;
      chk("cover_layer", bad, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    ready_i = 1'b1;
    step();
    step();
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_issue", 32'(issue_valid), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
    chk("rst_zeta", 32'(zeta_idx), 0);
    chk("rst_layer", 32'(layer), 0);
    chk("rst_wb", 32'(wb_valid), 0);
    chk("rst_done", 32'(done), 0);
    step();
    rst = 1'b0;
    step();

    begin_xfer(7 * (128 + P) + 1);
    wait_iss(400);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    end_checks();

    begin_xfer(7 * (128 + P) + 1 + 5);
    wait_iss(150);
    ready_i = 1'b0;
    repeat (5) step();
    ready_i = 1'b1;
    wait_done();
    end_checks();

    begin_xfer(-1);
    wait_iss(394);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_issue", 32'(issue_valid), 0);
    chk("mid_rst_wb", 32'(wb_valid), 0);
    chk("mid_rst_layer", 32'(layer), 0);
    step();
    step();

    begin_xfer(7 * (128 + P) + 1);
    wait_done();
    end_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
